// File: rtl/multicycle_carry_adder.sv
// Iterative carry-chain adder/subtractor.
// Sums CHUNK_WIDTH bits per clock, carry kept in a register between chunks.
module multicycle_carry_adder #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic                  carry_i,
    input  logic                  subtract_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic                  overflow_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int STEPS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    generate
        if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of CHUNK_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    carry_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;

    logic [CHUNK_WIDTH-1:0]  a_chunk;
    logic [CHUNK_WIDTH-1:0]  b_chunk;
    logic [CHUNK_WIDTH:0]    chunk_sum;
    logic                    msb_cin;

    // Select the active chunk of both operands and ripple-add it with the carry
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < STEPS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_chunk = a_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
                b_chunk = b_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
        chunk_sum = {1'b0, a_chunk}
                  + {1'b0, b_chunk}
                  + {{CHUNK_WIDTH{1'b0}}, carry_q};
        // Carry that entered the top bit of this chunk
        msb_cin = a_chunk[CHUNK_WIDTH-1]
                ^ b_chunk[CHUNK_WIDTH-1]
                ^ chunk_sum[CHUNK_WIDTH-1];
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            result_o   <= '0;
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
            ready_o    <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= operand_A_i;
                        b_q     <= subtract_i ? ~operand_B_i : operand_B_i;
                        carry_q <= subtract_i ? ~carry_i : carry_i;
                        cnt_q   <= '0;
                        ready_o <= 1'b0;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int k = 0; k < STEPS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            result_o[k*CHUNK_WIDTH +: CHUNK_WIDTH] <=
                                chunk_sum[CHUNK_WIDTH-1:0];
                        end
                    end
                    carry_q <= chunk_sum[CHUNK_WIDTH];
                    if (cnt_q == LAST) begin
                        carry_o    <= chunk_sum[CHUNK_WIDTH];
                        overflow_o <= msb_cin ^ chunk_sum[CHUNK_WIDTH];
                        valid_o    <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_carry_adder.sv
// Randomized and directed bench for multicycle_carry_adder.
// Index 0 is the 8-bit-chunk instance, index 1 the single-step instance.
module tb_multicycle_carry_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic        cin  [2];
    logic        sub  [2];
    logic        vi   [2];
    logic        ro   [2];
    logic [31:0] res  [2];
    logic        co   [2];
    logic        ov   [2];
    logic        vo   [2];
    logic        ri   [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_carry_adder #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst),
        .operand_A_i(op_a[0]), .operand_B_i(op_b[0]),
        .carry_i(cin[0]), .subtract_i(sub[0]), .valid_i(vi[0]),
        .ready_o(ro[0]), .result_o(res[0]), .carry_o(co[0]),
        .overflow_o(ov[0]), .valid_o(vo[0]), .ready_i(ri[0])
    );

    multicycle_carry_adder #(.DATA_WIDTH(32), .CHUNK_WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst),
        .operand_A_i(op_a[1]), .operand_B_i(op_b[1]),
        .carry_i(cin[1]), .subtract_i(sub[1]), .valid_i(vi[1]),
        .ready_o(ro[1]), .result_o(res[1]), .carry_o(co[1]),
        .overflow_o(ov[1]), .valid_o(vo[1]), .ready_i(ri[1])
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full words
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input bit c, input bit s,
                                  output logic [31:0] r, output bit cy,
                                  output bit of);
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        int     ia = a;
        int     ib = b;
        longint sa = ia;
        longint sb = ib;
        longint u;
        longint sv;
        logic [63:0] uv;
        if (s) begin
            u  = ua - ub - longint'(c);
            sv = sa - sb - longint'(c);
            cy = (u >= 0);
        end else begin
            u  = ua + ub + longint'(c);
            sv = sa + sb + longint'(c);
            cy = (u > 64'sd4294967295);
        end
        uv = u;
        r  = uv[31:0];
        of = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    endfunction

    task automatic do_op(input int u, input logic [31:0] a,
                         input logic [31:0] b, input bit c, input bit s,
                         input int hold, input bit junk);
        logic [31:0] er;
        bit          ec;
        bit          eo;
        int          lat;
        int          exp_lat;
        model(a, b, c, s, er, ec, eo);
        exp_lat = (u == 0) ? 5 : 2;
        @(negedge clk);
        chk("idle_ready", ro[u], 1'b1);
        op_a[u] = a;
        op_b[u] = b;
        cin[u]  = c;
        sub[u]  = s;
        vi[u]   = 1'b1;
        ri[u]   = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        chk("busy_ready", ro[u], 1'b0);
        if (junk) begin
            op_a[u] = ~a;
            op_b[u] = a ^ b;
            cin[u]  = ~c;
            sub[u]  = ~s;
        end else begin
            vi[u] = 1'b0;
        end
        while (!vo[u] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        vi[u] = 1'b0;
        chk("latency", lat, exp_lat);
        chk("result", res[u], er);
        chk("carry", co[u], ec);
        chk("overflow", ov[u], eo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", vo[u], 1'b1);
            chk("hold_ready", ro[u], 1'b0);
            chk("hold_result", {co[u], ov[u], res[u]}, {ec, eo, er});
        end
        ri[u] = 1'b1;
        @(posedge clk); #1;
        ri[u] = 1'b0;
        chk("release_valid", vo[u], 1'b0);
        chk("release_ready", ro[u], 1'b1);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 2; i++) begin
            op_a[i] = '0; op_b[i] = '0; cin[i] = 0;
            sub[i]  = 0;  vi[i]   = 0;  ri[i]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ro[0], 1'b1);
        chk("rst_valid", vo[0], 1'b0);
        chk("rst_out", {co[0], ov[0], res[0]}, 34'h0);
        rst = 1'b0;

        do_op(0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0);
        do_op(0, 32'h5, 32'h7, 0, 1, 0, 0);
        do_op(0, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0);
        do_op(0, 32'h0, 32'h0, 1, 0, 0, 0);
        do_op(0, 32'h8000_0000, 32'h1, 0, 1, 1, 0);
        do_op(0, 32'h1234_5678, 32'h0FED_CBA9, 1, 0, 3, 1);
        do_op(1, 32'h1234_5678, 32'h1111_1111, 0, 0, 0, 0);
        do_op(1, 32'hFFFF_FFFF, 32'h1, 0, 0, 2, 1);

        // Abort an operation once chunk 2 is current
        @(negedge clk);
        op_a[0] = 32'hAAAA_5555;
        op_b[0] = 32'h1357_9BDF;
        vi[0]   = 1'b1;
        @(posedge clk); #1;
        vi[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", vo[0], 1'b0);
        chk("abort_ready", ro[0], 1'b1);
        chk("abort_result", res[0], 32'h0);
        chk("abort_carry", co[0], 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (vo[0]) seen++;
        end
        chk("abort_no_pulse", seen, 0);
        do_op(0, 32'hAAAA_5555, 32'h1357_9BDF, 0, 1, 0, 0);

        for (int n = 0; n < 60; n++) begin
            do_op(n % 2, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
